apg_engine_v2: RTL and testbench
================================

Name: apg_engine_v2

Overview:
Next-generation arbitrary pattern generator core. It is parametrised in signal width and sample depth, and adds finite or continuous looping, abort, and streamed read-back of captured inputs through valid/ready handshakes. It sits behind the AXI-register wrapper layer on a single clock domain: pattern samples stream in, are played on output_signals while input_signals are captured, and the captured samples stream back out.

Parameters:
NUM_SIG, 8, width of output_signals/input_signals and of each sample word
NUM_SAMP, 128, depth of the pattern memory and of the capture memory, ≥2
IDLE_LEVEL, 0, value driven on output_signals whenever not in RUN (NUM_SIG bits)
AW (localparam), $clog2(NUM_SAMP+1), width of pointers and lengths

Ports:
wave_clk  in  1  sole clock
wave_reset  in  1  synchronous, active-high reset
run  in  1  single-cycle start pulse
abort  in  1  single-cycle stop pulse
clear_buffer  in  1  single-cycle pulse: empties the pattern buffer
n_samples  in  AW  samples per loop, sampled when run is accepted
loop_count  in  16  number of loops, 0 = continuous; sampled when run is accepted
wr_data  in  NUM_SIG  pattern sample to load
wr_valid  in  1  wr_data valid
wr_ready  out  1  pattern buffer accepts wr_data
rd_data  out  NUM_SIG  captured sample at rd_ptr
rd_valid  out  1  rd_data valid
rd_ready  in  1  consumer accepts rd_data
output_signals  out  NUM_SIG  registered pattern output
input_signals  in  NUM_SIG  signals to capture
write_buffer_len  out  AW  samples loaded (wr_ptr)
sample_count  out  32  samples driven since last accepted run, saturating at 2^32-1
status  out  3  [0] busy, [1] done (sticky), [2] error (sticky)
done  out  1  single-cycle pulse when a run ends, whether by completion or abort

Behaviour:
- Reset values: output_signals=IDLE_LEVEL, wr_ready=1, rd_valid=0, write_buffer_len=0, sample_count=0, status=0, done=0, state=IDLE.
- Reset clears pointers, counters and captured_len. Memory contents are not reset.
- Reset mid-RUN returns to IDLE immediately; done is not pulsed.
- States: IDLE, RUN.
- IDLE, load:
  - wr_ready = (wr_ptr<NUM_SAMP).
  - On wr_valid&wr_ready: pattern[wr_ptr]<=wr_data; wr_ptr++.
  - Writes with wr_ready=0 are dropped.
- IDLE, clear_buffer: wr_ptr<=0, captured_len<=0, status[2]<=0.
- IDLE, run accepted when 1≤n_samples≤wr_ptr:
  - State goes to RUN; idx<=0; loops_left<=loop_count; sample_count<=0; status[1]<=0; status[2]<=0.
  - Otherwise run is rejected: status[2]<=1 and the state stays IDLE.
- Priority in IDLE: clear_buffer > abort > run.
  - run together with clear_buffer or abort is ignored and does not set status[2].
- RUN, each edge:
  - output_signals<=pattern[idx]; sample_count++ (saturating).
  - Capture is delayed one cycle: capture[idx_d]<=input_signals, where idx_d is the idx of the previous edge. The input captured for sample i is therefore sampled during the cycle pattern[i] is driven.
  - idx wraps from n_samples-1 to 0.
  - At each wrap, loops_left decrements, unless loop_count=0.
- Last sample of the last loop: on the following edge, the final capture is written, output_signals<=IDLE_LEVEL, state<=IDLE, captured_len<=n_samples_latched, done=1, status[1]<=1.
- Latency: run accepted at edge k → pattern[0] is on output_signals after edge k+1.
  - Total RUN cycles = n_samples×loops + 1 (the extra cycle is the capture flush).
- Abort in RUN:
  - The next edge performs the pending capture, output_signals<=IDLE_LEVEL, state<=IDLE, done=1, status[1]<=1.
  - captured_len = n_samples if at least one loop completed, else the number of samples captured in the partial pass.
- RUN ignores run, clear_buffer, and wr_valid (wr_ready=0).
- status[0]=1 exactly while in RUN.
- Read-back:
  - rd_ptr<=0 on every entry to IDLE from RUN.
  - rd_valid = (state==IDLE)&&(rd_ptr<captured_len); rd_data=capture[rd_ptr], combinational from rd_ptr.
  - On rd_valid&rd_ready: rd_ptr++.
  - clear_buffer also zeroes rd_ptr.
- Continuous mode (loop_count=0) runs until abort. The captures from the final pass overwrite earlier passes.
- Widths: n_samples is compared against wr_ptr unsigned. n_samples>NUM_SAMP always rejects.

Test Plan:
- NUM_SIG=8, NUM_SAMP=4: load 0x11,0x22,0x33,0x44; a 5th write is dropped (wr_ready=0, write_buffer_len=4); run with n=4, loop=1 → output 11,22,33,44 on consecutive cycles starting 1 cycle after run, then 0x00; done pulses once; status=3'b010.
- Loop: n=3, loop=2 → output 11,22,33,11,22,33; sample_count=6; input_signals=0xA0+idx → read-back gives A0,A1,A2 with rd_ready held low for 2 cycles mid-stream (data holds).
- Reject: wr_ptr=2, run with n=3 → status[2]=1, stays IDLE; run with n=0 → status[2]=1; then clear_buffer → status[2]=0, write_buffer_len=0.
- Continuous: loop=0, n=2, abort after 5 driven samples → output 11,22,11,22,11, then IDLE_LEVEL; done=1; captured_len=2.
- Abort in first pass after 2 of n=4 samples → 2 samples readable; simultaneous run+abort in IDLE → no start, no error.
- wave_reset asserted mid-RUN → next edge output=IDLE_LEVEL, status=0, no done pulse; reload and run succeed.

Source files
------------

// File: rtl/apg_engine_v2.sv
// ============================================================================
//  Module   : apg_engine_v2
//  Brief    : Arbitrary pattern generator with looping, abort and streamed
//             read-back of the inputs captured while the pattern plays.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module apg_engine_v2 #(
    parameter int                 NUM_SIG    = 8,
    parameter int                 NUM_SAMP   = 128,
    parameter logic [NUM_SIG-1:0] IDLE_LEVEL = '0
) (
    input  logic                            wave_clk,
    input  logic                            wave_reset,
    input  logic                            run,
    input  logic                            abort,
    input  logic                            clear_buffer,
    input  logic [$clog2(NUM_SAMP+1)-1:0]   n_samples,
    input  logic [15:0]                     loop_count,
    input  logic [NUM_SIG-1:0]              wr_data,
    input  logic                            wr_valid,
    output logic                            wr_ready,
    output logic [NUM_SIG-1:0]              rd_data,
    output logic                            rd_valid,
    input  logic                            rd_ready,
    output logic [NUM_SIG-1:0]              output_signals,
    input  logic [NUM_SIG-1:0]              input_signals,
    output logic [$clog2(NUM_SAMP+1)-1:0]   write_buffer_len,
    output logic [31:0]                     sample_count,
    output logic [2:0]                      status,
    output logic                            done
);

    localparam int AW = $clog2(NUM_SAMP + 1);
    localparam int IW = $clog2(NUM_SAMP);

    localparam logic [0:0]    c_ST_IDLE = 1'b0;
    localparam logic [0:0]    c_ST_RUN  = 1'b1;
    localparam logic [AW-1:0] c_DEPTH   = AW'(NUM_SAMP);
    localparam logic [AW-1:0] c_ONE     = AW'(1);

    logic [NUM_SIG-1:0] r_pattern [NUM_SAMP];
    logic [NUM_SIG-1:0] r_capture [NUM_SAMP];

    logic [0:0]         r_state;
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW-1:0]      r_captured_len;
    logic [AW-1:0]      r_idx;
    logic [AW-1:0]      r_idx_d;
    logic [AW-1:0]      r_n_lat;
    logic [15:0]        r_loops_left;
    logic               r_cap_pending;
    logic               r_flush;
    logic               r_wrapped;
    logic [31:0]        r_sample_count;
    logic               r_done_sticky;
    logic               r_err;
    logic               r_done_pulse;
    logic [NUM_SIG-1:0] r_out;

    logic w_in_run;
    logic w_wr_ready;
    logic w_rd_valid;
    logic w_run_ok;
    logic w_last_in_pass;
    logic w_last_sample;

    assign w_in_run       = (r_state == c_ST_RUN);
    assign w_wr_ready     = !w_in_run && (r_wr_ptr < c_DEPTH);
    assign w_rd_valid     = !w_in_run && (r_rd_ptr < r_captured_len);
    assign w_run_ok       = (n_samples != '0) && (n_samples <= r_wr_ptr);
    assign w_last_in_pass = (r_idx == r_n_lat - c_ONE);
    // loops_left of zero means continuous mode, so it never terminates a run
    assign w_last_sample  = w_last_in_pass && (r_loops_left == 16'd1);

    assign wr_ready         = w_wr_ready;
    assign rd_valid         = w_rd_valid;
    assign rd_data          = r_capture[r_rd_ptr[IW-1:0]];
    assign output_signals   = r_out;
    assign write_buffer_len = r_wr_ptr;
    assign sample_count     = r_sample_count;
    assign status           = {r_err, r_done_sticky, w_in_run};
    assign done             = r_done_pulse;

    always_ff @(posedge wave_clk) begin
        if (!wave_reset) begin
            if (w_wr_ready && wr_valid && !clear_buffer) begin
                r_pattern[r_wr_ptr[IW-1:0]] <= wr_data;
            end
            // Capture lags the drive by one edge so the input seen while a
            // sample is on the pins lands at that sample's index.
            if (w_in_run && r_cap_pending) begin
                r_capture[r_idx_d[IW-1:0]] <= input_signals;
            end
        end
    end

    always_ff @(posedge wave_clk) begin
        if (wave_reset) begin
            r_state        <= c_ST_IDLE;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_captured_len <= '0;
            r_idx          <= '0;
            r_idx_d        <= '0;
            r_n_lat        <= '0;
            r_loops_left   <= '0;
            r_cap_pending  <= 1'b0;
            r_flush        <= 1'b0;
            r_wrapped      <= 1'b0;
            r_sample_count <= '0;
            r_done_sticky  <= 1'b0;
            r_err          <= 1'b0;
            r_done_pulse   <= 1'b0;
            r_out          <= IDLE_LEVEL;
        end else begin
            r_done_pulse <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_out <= IDLE_LEVEL;
                    if (clear_buffer) begin
                        r_wr_ptr       <= '0;
                        r_captured_len <= '0;
                        r_rd_ptr       <= '0;
                        r_err          <= 1'b0;
                    end else begin
                        if (w_wr_ready && wr_valid) begin
                            r_wr_ptr <= r_wr_ptr + c_ONE;
                        end
                        if (w_rd_valid && rd_ready) begin
                            r_rd_ptr <= r_rd_ptr + c_ONE;
                        end
                        if (run && !abort) begin
                            if (w_run_ok) begin
                                r_state        <= c_ST_RUN;
                                r_idx          <= '0;
                                r_idx_d        <= '0;
                                r_n_lat        <= n_samples;
                                r_loops_left   <= loop_count;
                                r_cap_pending  <= 1'b0;
                                r_flush        <= 1'b0;
                                r_wrapped      <= 1'b0;
                                r_sample_count <= '0;
                                r_done_sticky  <= 1'b0;
                                r_err          <= 1'b0;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                end

                c_ST_RUN: begin
                    if (abort || r_flush) begin
                        r_state       <= c_ST_IDLE;
                        r_out         <= IDLE_LEVEL;
                        r_done_pulse  <= 1'b1;
                        r_done_sticky <= 1'b1;
                        r_rd_ptr      <= '0;
                        r_cap_pending <= 1'b0;
                        r_flush       <= 1'b0;
                        if (r_flush || r_wrapped) begin
                            r_captured_len <= r_n_lat;
                        end else if (r_cap_pending) begin
                            r_captured_len <= r_idx_d + c_ONE;
                        end else begin
                            r_captured_len <= '0;
                        end
                    end else begin
                        r_out         <= r_pattern[r_idx[IW-1:0]];
                        r_idx_d       <= r_idx;
                        r_cap_pending <= 1'b1;
                        if (r_sample_count != 32'hFFFF_FFFF) begin
                            r_sample_count <= r_sample_count + 32'd1;
                        end
                        if (w_last_in_pass) begin
                            r_idx     <= '0;
                            r_wrapped <= 1'b1;
                            if (r_loops_left != 16'd0) begin
                                r_loops_left <= r_loops_left - 16'd1;
                            end
                        end else begin
                            r_idx <= r_idx + c_ONE;
                        end
                        if (w_last_sample) begin
                            r_flush <= 1'b1;
                        end
                    end
                end

                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_apg_engine_v2.sv
// ============================================================================
//  Module   : tb_apg_engine_v2
//  Brief    : Directed and randomized bench for apg_engine_v2 with an
//             in-bench sample-level reference model.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_apg_engine_v2;

    localparam int              NUM_SIG    = 8;
    localparam int              NUM_SAMP   = 4;
    localparam int              AW         = $clog2(NUM_SAMP + 1);
    localparam logic [7:0]      IDLE_LEVEL = 8'h00;

    logic              wave_clk      = 1'b0;
    logic              wave_reset    = 1'b1;
    logic              run           = 1'b0;
    logic              abort         = 1'b0;
    logic              clear_buffer  = 1'b0;
    logic [AW-1:0]     n_samples     = '0;
    logic [15:0]       loop_count    = '0;
    logic [7:0]        wr_data       = '0;
    logic              wr_valid      = 1'b0;
    logic              wr_ready;
    logic [7:0]        rd_data;
    logic              rd_valid;
    logic              rd_ready      = 1'b0;
    logic [7:0]        output_signals;
    logic [7:0]        input_signals = '0;
    logic [AW-1:0]     write_buffer_len;
    logic [31:0]       sample_count;
    logic [2:0]        status;
    logic              done;

    apg_engine_v2 #(
        .NUM_SIG    (NUM_SIG),
        .NUM_SAMP   (NUM_SAMP),
        .IDLE_LEVEL (IDLE_LEVEL)
    ) dut (
        .wave_clk         (wave_clk),
        .wave_reset       (wave_reset),
        .run              (run),
        .abort            (abort),
        .clear_buffer     (clear_buffer),
        .n_samples        (n_samples),
        .loop_count       (loop_count),
        .wr_data          (wr_data),
        .wr_valid         (wr_valid),
        .wr_ready         (wr_ready),
        .rd_data          (rd_data),
        .rd_valid         (rd_valid),
        .rd_ready         (rd_ready),
        .output_signals   (output_signals),
        .input_signals    (input_signals),
        .write_buffer_len (write_buffer_len),
        .sample_count     (sample_count),
        .status           (status),
        .done             (done)
    );

    always #5 wave_clk = ~wave_clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a run is "sample t of n*loops", output = pattern[t % n]
    logic [7:0] m_pat [NUM_SAMP];
    logic [7:0] m_cap [NUM_SAMP];
    int         m_wr_len, m_rd, m_cap_len, m_cnt, m_n, m_loops;
    bit         m_run, m_err, m_dsticky, m_done, m_ok;
    logic [7:0] m_out;

    always @(posedge wave_clk) begin
        m_done = 1'b0;
        if (wave_reset) begin
            m_run = 0; m_wr_len = 0; m_rd = 0; m_cap_len = 0; m_cnt = 0;
            m_n = 1; m_loops = 0; m_err = 0; m_dsticky = 0; m_out = IDLE_LEVEL;
        end else if (!m_run) begin
            m_out = IDLE_LEVEL;
            if (clear_buffer) begin
                m_wr_len = 0; m_cap_len = 0; m_rd = 0; m_err = 0;
            end else begin
                if (rd_ready && m_rd < m_cap_len) m_rd++;
                m_ok = (int'(n_samples) >= 1) && (int'(n_samples) <= m_wr_len);
                if (wr_valid && m_wr_len < NUM_SAMP) begin
                    m_pat[m_wr_len] = wr_data;
                    m_wr_len++;
                end
                if (run && !abort) begin
                    if (m_ok) begin
                        m_run = 1; m_n = int'(n_samples); m_loops = int'(loop_count);
                        m_cnt = 0; m_dsticky = 0; m_err = 0;
                    end else begin
                        m_err = 1;
                    end
                end
            end
        end else begin
            if (m_cnt > 0) m_cap[(m_cnt - 1) % m_n] = input_signals;
            if (abort || (m_loops != 0 && m_cnt == m_n * m_loops)) begin
                m_run = 0; m_out = IDLE_LEVEL; m_done = 1; m_dsticky = 1; m_rd = 0;
                m_cap_len = (m_cnt >= m_n) ? m_n : m_cnt;
            end else begin
                m_out = m_pat[m_cnt % m_n];
                m_cnt++;
            end
        end
    end

    always @(negedge wave_clk) begin
        if (chk_en) begin
            chk("output_signals", 32'(output_signals), 32'(m_out));
            chk("wr_ready", 32'(wr_ready), 32'(!m_run && m_wr_len < NUM_SAMP));
            chk("write_buffer_len", 32'(write_buffer_len), 32'(m_wr_len));
            chk("sample_count", sample_count, 32'(m_cnt));
            chk("status", 32'(status), 32'({m_err, m_dsticky, m_run}));
            chk("done", 32'(done), 32'(m_done));
            chk("rd_valid", 32'(rd_valid), 32'(!m_run && m_rd < m_cap_len));
            if (!m_run && m_rd < m_cap_len) chk("rd_data", 32'(rd_data), 32'(m_cap[m_rd]));
        end
    end

    task automatic tick();
        @(posedge wave_clk);
        #1;
    endtask

    task automatic write_word(input logic [7:0] d);
        wr_valid = 1'b1; wr_data = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic start(input int n, input int loops);
        n_samples = AW'(n); loop_count = 16'(loops); run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_buffer = 1'b1;
        tick();
        clear_buffer = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    logic [7:0] seq [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    initial begin
        repeat (3) tick();
        chk_en = 1'b1;
        chk("reset out", 32'(output_signals), 32'h00);
        chk("reset wr_ready", 32'(wr_ready), 32'h1);
        chk("reset status", 32'(status), 32'h0);
        wave_reset = 1'b0;

        // Load four words, fifth is dropped; single pass of 4
        for (int i = 0; i < 4; i++) write_word(seq[i]);
        chk("full wr_ready", 32'(wr_ready), 32'h0);
        write_word(8'h55);
        chk("full len", 32'(write_buffer_len), 32'd4);
        start(4, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("seq single", 32'(output_signals), 32'(seq[i]));
        end
        tick();
        chk("single end out", 32'(output_signals), 32'h00);
        chk("single done", 32'(done), 32'h1);
        chk("single status", 32'(status), 32'b010);
        tick();
        chk("done one cycle", 32'(done), 32'h0);

        // Two loops of 3 with tagged inputs, then stalled read-back
        start(3, 2);
        for (int j = 0; j < 6; j++) begin
            tick();
            input_signals = 8'hA0 + 8'(j % 3);
            chk("seq loop", 32'(output_signals), 32'(seq[j % 3]));
        end
        tick();
        input_signals = 8'h00;
        chk("loop count", sample_count, 32'd6);
        chk("rb0", 32'(rd_data), 32'hA0);
        rd_ready = 1'b1; tick(); rd_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("rb hold", 32'(rd_data), 32'hA1);
            if (k < 2) tick();
        end
        rd_ready = 1'b1; tick();
        chk("rb2", 32'(rd_data), 32'hA2);
        tick();
        chk("rb end", 32'(rd_valid), 32'h0);
        rd_ready = 1'b0;

        // Rejected starts and error clear
        pulse_clear();
        write_word(8'h11); write_word(8'h22);
        start(3, 1);
        chk("reject n>len", 32'(status[2:0]), 32'b110);
        pulse_clear();
        write_word(8'h11); write_word(8'h22);
        start(0, 1);
        chk("reject n=0", 32'(status[2]), 32'h1);
        pulse_clear();
        chk("clear err", 32'(status[2]), 32'h0);
        chk("clear len", 32'(write_buffer_len), 32'h0);

        // Continuous mode, abort after five samples
        for (int i = 0; i < 4; i++) write_word(seq[i]);
        start(2, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("seq cont", 32'(output_signals), 32'(seq[i % 2]));
        end
        pulse_abort();
        chk("cont abort out", 32'(output_signals), 32'h00);
        chk("cont abort done", 32'(done), 32'h1);
        rd_ready = 1'b1; tick(); tick();
        chk("cont captured 2", 32'(rd_valid), 32'h0);
        rd_ready = 1'b0;

        // Abort inside first pass after two samples
        start(4, 1);
        tick(); tick();
        pulse_abort();
        rd_ready = 1'b1; tick();
        chk("partial rd1", 32'(rd_valid), 32'h1);
        tick();
        chk("partial rd2", 32'(rd_valid), 32'h0);
        rd_ready = 1'b0;
        n_samples = AW'(2); run = 1'b1; abort = 1'b1;
        tick();
        run = 1'b0; abort = 1'b0;
        chk("run+abort", 32'(status), 32'b010);

        // Reset mid-run, then reload and run
        start(4, 3);
        repeat (3) tick();
        wave_reset = 1'b1; tick(); wave_reset = 1'b0;
        chk("rst out", 32'(output_signals), 32'h00);
        chk("rst status", 32'(status), 32'h0);
        chk("rst done", 32'(done), 32'h0);
        write_word(8'h11); write_word(8'h22);
        start(2, 1);
        tick(); chk("post rst s0", 32'(output_signals), 32'h11);
        tick(); chk("post rst s1", 32'(output_signals), 32'h22);
        tick(); chk("post rst done", 32'(done), 32'h1);

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            wr_valid      = 1'($urandom_range(0, 1));
            wr_data       = 8'($urandom);
            run           = ($urandom_range(0, 7) == 0);
            abort         = ($urandom_range(0, 24) == 0);
            clear_buffer  = ($urandom_range(0, 39) == 0);
            n_samples     = AW'($urandom_range(0, 5));
            loop_count    = 16'($urandom_range(0, 3));
            rd_ready      = 1'($urandom_range(0, 1));
            input_signals = 8'($urandom);
            wave_reset    = ($urandom_range(0, 249) == 0);
            tick();
        end
        wr_valid = 0; run = 0; clear_buffer = 0; rd_ready = 0; wave_reset = 0;
        abort = 1'b1; tick(); abort = 1'b0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
